mro_trng_ctrl: RTL
==================

// Module: mro_trng_ctrl
// PURPOSE
//  Sequences a bank of free-running ring oscillators for the TRNG. Releases the ROs from
//  reset and waits a warm-up period. Then samples the RO outputs through 2-FF synchronisers
//  and XOR-reduces them to one raw bit every SAMPLE_DIV clocks. Packs raw bits into WORD_W
//  words and delivers them over a valid/ready handshake. Sits between the RO array and the
//  random-word consumer.
// PARAMETERS
//  N_RO        32   number of RO outputs sampled (width of RO_IN)
//  WORD_W      32   output word width, >=2
//  WARMUP_CYC  256  clocks the ROs run after release before sampling starts, >=1
//  SAMPLE_DIV  8    clocks per raw bit, >=1
//  REP_LIMIT   16   repetition-count cutoff for the health test, >=2
// PORTS
//  CLK          in   1       system clock
//  RESET        in   1       asynchronous, active-high reset
//  EN           in   1       run request; level-sensitive
//  RO_IN        in   N_RO    asynchronous RO outputs
//  RO_RESET     out  1       drives RO reset; 1 = ROs held stopped
//  RND_DATA     out  WORD_W  random word; stable while RND_VALID=1
//  RND_VALID    out  1       word available
//  RND_READY    in   1       consumer accepts the word when RND_VALID & RND_READY
//  BUSY         out  1       1 in WARMUP/COLLECT/HOLD
//  HEALTH_FAIL  out  1       sticky health-test failure
// BEHAVIOUR
//  Reset: state IDLE, RO_RESET=1, RND_VALID=0, RND_DATA=0, BUSY=0, HEALTH_FAIL=0.
//   All counters, shift register and synchroniser flops clear to 0. All outputs are registered.
//  IDLE: RO_RESET=1. If EN=1 at edge t, then at t+1: state WARMUP, RO_RESET=0, BUSY=1,
//   warm-up counter loaded.
//  WARMUP: lasts exactly WARMUP_CYC cycles, then COLLECT. Synchronisers run and results are ignored.
//  COLLECT: divider counts 1..SAMPLE_DIV. On the SAMPLE_DIV-th cycle:
//   - raw = ^sync2[N_RO-1:0]
//   - shreg <= {shreg[WORD_W-2:0], raw}; first bit ends up at MSB
//   - bitcnt increments
//   When the WORD_W-th bit is taken, RND_DATA <= completed word and RND_VALID=1 on the same
//   edge; state -> HOLD. First word: RND_VALID rises at t+1+WARMUP_CYC+WORD_W*SAMPLE_DIV.
//  HOLD: ROs keep running, no sampling, divider and bitcnt frozen at 0. RND_DATA stable.
//   VALID & READY at edge e: at e+1, RND_VALID=0, state COLLECT with fresh divider and bitcnt.
//   Next word is valid WORD_W*SAMPLE_DIV cycles after COLLECT re-entry. No overlap, no loss.
//  EN=0 sampled in any non-IDLE state: at next edge, state IDLE, RO_RESET=1, RND_VALID=0,
//   BUSY=0, partial word discarded. RND_DATA keeps its last value.
//   A handshake completing on that same edge counts as accepted.
//   EN re-asserted later restarts the full warm-up.
//  Asynchronous RESET at any time, including mid-HOLD, forces reset values immediately.
//   A pending word is lost.
//  Counter widths sized with $clog2; no wrap occurs within a state.
// CONFIGURATION
//  HEALTH_TEST_EN defined:
//   - repetition counter tracks consecutive equal raw bits; cleared in IDLE/WARMUP.
//   - When the count reaches REP_LIMIT, on that edge: HEALTH_FAIL=1, state FAIL,
//     RO_RESET=1, RND_VALID=0, BUSY=0; the word in progress is discarded.
//   - FAIL is left only by RESET. EN has no effect in FAIL.
//  HEALTH_TEST_EN undefined: no repetition logic, no FAIL state, HEALTH_FAIL tied 0.
// TESTING (bench params: N_RO=32 WORD_W=8 WARMUP_CYC=4 SAMPLE_DIV=2 REP_LIMIT=16)
//  1 Assert RESET -> RO_RESET=1, RND_VALID=0, RND_DATA=0, BUSY=0, HEALTH_FAIL=0. Idle 20 cycles
//    with EN=0 -> unchanged.
//  2 RO_IN=32'h0000_0001, RND_READY=1, EN=1 at t -> RO_RESET=0 at t+1; RND_VALID=1 at t+21
//    with RND_DATA=8'hFF; next word 8'hFF at t+38.
//  3 RO_IN toggles 32'h1/32'h0 every 2 cycles, aligned to sampling -> RND_DATA=8'hAA or
//    8'h55 (phase-checked).
//  4 Word pending, RND_READY=0 for 50 cycles -> RND_VALID held 1, RND_DATA stable;
//    READY=1 -> VALID=0 next cycle, next word 16 cycles later.
//  5 EN dropped after 3 bits collected -> IDLE and RO_RESET=1 next edge, VALID=0;
//    EN re-raised at u -> first word at u+21.
//  6 (HEALTH_TEST_EN) RO_IN=32'h1 constant -> word 8'hFF delivered, then HEALTH_FAIL=1 on the
//    16th sample; RO_RESET=1, EN toggles ignored until RESET. Without macro: HEALTH_FAIL stays 0.

Source files
------------

// File: rtl/mro_trng_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, synchronised XOR sampling, word packing, valid/ready delivery.
// Define HEALTH_TEST_EN to add the repetition-count health test and its sticky FAIL state.
module mro_trng_ctrl #(
  parameter int N_RO       = 32,
  parameter int WORD_W     = 32,
  parameter int WARMUP_CYC = 256,
  parameter int SAMPLE_DIV = 8,
  parameter int REP_LIMIT  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [N_RO-1:0]   RO_IN,
  output logic              RO_RESET,
  output logic [WORD_W-1:0] RND_DATA,
  output logic              RND_VALID,
  input  logic              RND_READY,
  output logic              BUSY,
  output logic              HEALTH_FAIL
);
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
  localparam int BIT_W  = $clog2(WORD_W + 1);

`ifdef HEALTH_TEST_EN
  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD} state_t;
`endif

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [WORD_W-2:0]   shreg_q, shreg_d;
  logic [N_RO-1:0]     sync1_q, sync2_q;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ro_reset_q, ro_reset_d;
  logic                busy_q, busy_d;
  logic                raw, sample;
  logic [WORD_W-1:0]   next_word;

  assign raw       = ^sync2_q;
  assign sample    = (state_q == S_COLLECT) && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign next_word = {shreg_q, raw};

`ifdef HEALTH_TEST_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic             last_raw_q, last_raw_d;
  logic             hfail_q, hfail_d;
`endif

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    div_d      = div_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ro_reset_d = ro_reset_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          state_d    = S_WARMUP;
          warm_d     = WARM_W'(WARMUP_CYC);
          div_d      = '0;
          bitcnt_d   = '0;
          shreg_d    = '0;
          ro_reset_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_WARMUP: begin
        if (warm_q == WARM_W'(1)) state_d = S_COLLECT;
        else                      warm_d  = warm_q - WARM_W'(1);
      end
      S_COLLECT: begin
        if (sample) begin
          div_d   = '0;
          shreg_d = next_word[WORD_W-2:0];
          if (bitcnt_q == BIT_W'(WORD_W - 1)) begin
            bitcnt_d = '0;
            data_d   = next_word;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end else begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (RND_READY) begin
          valid_d = 1'b0;
          state_d = S_COLLECT;
        end
      end
      default: ;
    endcase

`ifdef HEALTH_TEST_EN
    rep_d      = rep_q;
    last_raw_d = last_raw_q;
    hfail_d    = hfail_q;
    if (state_q == S_IDLE || state_q == S_WARMUP) begin
      rep_d = '0;
    end else if (sample) begin
      rep_d      = (rep_q != '0 && raw == last_raw_q) ? rep_q + REP_W'(1) : REP_W'(1);
      last_raw_d = raw;
      if (rep_d == REP_W'(REP_LIMIT)) begin
        state_d    = S_FAIL;
        hfail_d    = 1'b1;
        ro_reset_d = 1'b1;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        div_d      = '0;
        bitcnt_d   = '0;
        shreg_d    = '0;
        data_d     = data_q;
      end
    end
`endif

    // Dropping EN wins over any sample or health event on the same edge; the last delivered word stays visible.
    if (!EN && (state_q inside {S_WARMUP, S_COLLECT, S_HOLD})) begin
      state_d    = S_IDLE;
      ro_reset_d = 1'b1;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      warm_d     = '0;
      div_d      = '0;
      bitcnt_d   = '0;
      shreg_d    = '0;
      data_d     = data_q;
`ifdef HEALTH_TEST_EN
      hfail_d    = hfail_q;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      warm_q     <= '0;
      div_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ro_reset_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      div_q      <= div_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      sync1_q    <= RO_IN;
      sync2_q    <= sync1_q;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ro_reset_q <= ro_reset_d;
      busy_q     <= busy_d;
    end
  end

`ifdef HEALTH_TEST_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rep_q      <= '0;
      last_raw_q <= 1'b0;
      hfail_q    <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      last_raw_q <= last_raw_d;
      hfail_q    <= hfail_d;
    end
  end
  assign HEALTH_FAIL = hfail_q;
`else
  assign HEALTH_FAIL = 1'b0;
`endif

  assign RO_RESET  = ro_reset_q;
  assign RND_DATA  = data_q;
  assign RND_VALID = valid_q;
  assign BUSY      = busy_q;
endmodule
